// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode encodings, status flag bit positions and the
// per-mode status update mask.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned MODE_W = 4;

  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_S = 1;
  localparam int unsigned FLG_O = 0;

  typedef logic [MODE_W-1:0] mode_t;
  typedef logic [FLAG_W-1:0] flags_t;

  localparam mode_t MODE_ADD  = 4'b0000;
  localparam mode_t MODE_SUB  = 4'b0001;
  localparam mode_t MODE_AND  = 4'b0010;
  localparam mode_t MODE_OR   = 4'b0011;
  localparam mode_t MODE_XOR  = 4'b0100;
  localparam mode_t MODE_NOT  = 4'b0101;
  localparam mode_t MODE_SHL  = 4'b0110;
  localparam mode_t MODE_INC  = 4'b0111;
  localparam mode_t MODE_ADC  = 4'b1000;
  localparam mode_t MODE_SBB  = 4'b1001;
  localparam mode_t MODE_SHR  = 4'b1010;
  localparam mode_t MODE_ROL  = 4'b1011;
  localparam mode_t MODE_ROR  = 4'b1100;
  localparam mode_t MODE_PASS = 4'b1101;
  localparam mode_t MODE_CLR  = 4'b1110;
  localparam mode_t MODE_NEG  = 4'b1111;

  // Arithmetic modes own the carry; everything else leaves C untouched.
  function automatic flags_t flag_mask(input mode_t mode);
    flags_t m;
    m = '1;
    case (mode)
      MODE_ADD, MODE_SUB, MODE_INC, MODE_ADC, MODE_SBB, MODE_NEG: m = '1;
      default: m[FLG_C] = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_status_writeback_if.sv
// ALU-result / status / data-memory write bundle between the ALU environment
// and the status-writeback stage.
interface alu_status_writeback_if
  import alu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic                alu_e;
  mode_t               mode;
  logic [DATA_W-1:0]   alu_out;
  flags_t              alu_flags;
  logic                wb_en;
  logic [ADDR_W-1:0]   dst_addr;
  logic                flag_we;
  flags_t              flag_wdata;
  flags_t              cflags;
  logic                stall;
  logic                busy;
  logic                ovf_err;
  logic                dmem_we;
  logic [ADDR_W-1:0]   dmem_addr;
  logic [DATA_W-1:0]   dmem_di;
  logic                dmem_ack;

  modport master (
    output alu_e, mode, alu_out, alu_flags, wb_en, dst_addr, flag_we, flag_wdata, dmem_ack,
    input  cflags, stall, busy, ovf_err, dmem_we, dmem_addr, dmem_di
  );

  modport slave (
    input  alu_e, mode, alu_out, alu_flags, wb_en, dst_addr, flag_we, flag_wdata, dmem_ack,
    output cflags, stall, busy, ovf_err, dmem_we, dmem_addr, dmem_di
  );

endinterface

// File: rtl/alu_status_writeback_wb_fifo.sv
// Writeback buffer: DEPTH-entry circular FIFO exposing the head and the entry
// behind it so the write port can advance without a bubble.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata_c,
  output logic [WIDTH-1:0]           o_rdata_nxt_c,
  output logic                       o_full_c,
  output logic                       o_empty_c,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_rd_ptr_nxt;

  assign w_rd_ptr_nxt  = r_rd_ptr + PTR_W'(1);
  assign o_rdata_c     = r_mem[r_rd_ptr];
  assign o_rdata_nxt_c = r_mem[w_rd_ptr_nxt];
  assign o_full_c      = (r_count == CNT_W'(DEPTH));
  assign o_empty_c     = (r_count == '0);
  assign o_count       = r_count;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_status_writeback.sv
// ALU downstream stage: architectural status register fed back to the ALU,
// plus a buffered req/ack write path from ALU results to data memory.
module alu_status_writeback
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_status_writeback_if.slave  bus
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  flags_t             r_cflags;
  flags_t             w_cflags_nxt;
  flags_t             w_mask;
  logic               r_ovf_err;
  logic [ADDR_W-1:0]  r_dmem_addr;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [DATA_W-1:0]  r_dmem_di;
  logic [DATA_W-1:0]  w_di_nxt;
  logic               w_capture;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_wr_data;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_head_nxt;
  logic [CNT_W-1:0]   w_count;

  assign w_capture = bus.alu_e & bus.wb_en;
  assign w_push    = w_capture & ~w_full;
  assign w_pop     = (r_state == ST_WRITE) & bus.dmem_ack;
  assign w_wr_data = {bus.dst_addr, bus.alu_out};
  assign w_mask    = flag_mask(bus.mode);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wb_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (w_push),
    .i_wdata       (w_wr_data),
    .i_pop         (w_pop),
    .o_rdata_c     (w_head),
    .o_rdata_nxt_c (w_head_nxt),
    .o_full_c      (w_full),
    .o_empty_c     (w_empty),
    .o_count       (w_count)
  );

  // Status register next value; a direct load overrides the ALU update.
  always_comb begin
    w_cflags_nxt = r_cflags;
    if (bus.alu_e) begin
      w_cflags_nxt = (r_cflags & ~w_mask) | (bus.alu_flags & w_mask);
    end
    if (bus.flag_we) begin
      w_cflags_nxt = bus.flag_wdata;
    end
  end

  // Write FSM; the address/data registers always hold the entry being offered.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_dmem_addr;
    w_di_nxt    = r_dmem_di;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt            = ST_WRITE;
          {w_addr_nxt, w_di_nxt} = w_head;
        end
      end
      ST_WRITE: begin
        if (bus.dmem_ack) begin
          if (w_count > CNT_W'(1)) begin
            {w_addr_nxt, w_di_nxt} = w_head_nxt;
          end else if (w_push) begin
            {w_addr_nxt, w_di_nxt} = w_wr_data;
          end else begin
            w_state_nxt = ST_IDLE;
            w_addr_nxt  = '0;
            w_di_nxt    = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = '0;
        w_di_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cflags    <= '0;
      r_ovf_err   <= 1'b0;
      r_dmem_addr <= '0;
      r_dmem_di   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cflags    <= w_cflags_nxt;
      r_dmem_addr <= w_addr_nxt;
      r_dmem_di   <= w_di_nxt;
      if (w_capture & w_full) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  assign bus.cflags    = r_cflags;
  assign bus.stall     = w_full;
  assign bus.busy      = (w_count != '0) | (r_state == ST_WRITE);
  assign bus.ovf_err   = r_ovf_err;
  assign bus.dmem_we   = (r_state == ST_WRITE);
  assign bus.dmem_addr = r_dmem_addr;
  assign bus.dmem_di   = r_dmem_di;

endmodule

// File: tb/tb_alu_status_writeback.sv
// Self-checking bench for alu_status_writeback: directed scenarios followed by
// random traffic, compared cycle by cycle against a queue-based reference.
module tb_alu_status_writeback;

  localparam int unsigned DEPTH = 2;

  logic clk;
  logic rst_n;

  alu_status_writeback_if #(.ADDR_W(8)) bus ();

  alu_status_writeback #(
    .DEPTH  (DEPTH),
    .ADDR_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: status value, sticky error, queued {addr,data} entries,
  // and whether a write request is currently being offered to memory.
  logic [3:0]  m_cflags;
  logic        m_ovf;
  logic        m_writing;
  logic [15:0] m_q [$];
  logic [15:0] obs_q [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_arith(input logic [3:0] mode);
    return (mode == 4'd0) || (mode == 4'd1) || (mode == 4'd7) ||
           (mode == 4'd8) || (mode == 4'd9) || (mode == 4'd15);
  endfunction

  task automatic model_reset();
    m_cflags  = 4'b0000;
    m_ovf     = 1'b0;
    m_writing = 1'b0;
    m_q.delete();
  endtask

  // Apply one clock edge worth of behaviour to the reference.
  task automatic model_edge();
    bit full, cap, push, pop;
    int pre;
    pre  = m_q.size();
    full = (pre == DEPTH);
    cap  = bus.alu_e && bus.wb_en;
    push = cap && !full;
    pop  = m_writing && bus.dmem_ack;
    if (cap && full) m_ovf = 1'b1;
    if (bus.flag_we) m_cflags = bus.flag_wdata;
    else if (bus.alu_e) begin
      if (is_arith(bus.mode)) m_cflags = bus.alu_flags;
      else m_cflags = {bus.alu_flags[3], m_cflags[2], bus.alu_flags[1:0]};
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back({bus.dst_addr, bus.alu_out});
    if (!m_writing) m_writing = (pre != 0);
    else if (pop) m_writing = (m_q.size() != 0);
  endtask

  task automatic check_all();
    logic [15:0] head;
    head = m_writing ? m_q[0] : 16'h0000;
    chk("cflags",    16'(bus.cflags),    16'(m_cflags));
    chk("stall",     16'(bus.stall),     16'(m_q.size() == DEPTH));
    chk("busy",      16'(bus.busy),      16'((m_q.size() != 0) || m_writing));
    chk("ovf_err",   16'(bus.ovf_err),   16'(m_ovf));
    chk("dmem_we",   16'(bus.dmem_we),   16'(m_writing));
    chk("dmem_addr", 16'(bus.dmem_addr), 16'(head[15:8]));
    chk("dmem_di",   16'(bus.dmem_di),   16'(head[7:0]));
  endtask

  task automatic cycle();
    if (bus.dmem_we && bus.dmem_ack) obs_q.push_back({bus.dmem_addr, bus.dmem_di});
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    bus.alu_e      = 1'b0;
    bus.mode       = 4'd0;
    bus.alu_out    = 8'h00;
    bus.alu_flags  = 4'b0000;
    bus.wb_en      = 1'b0;
    bus.dst_addr   = 8'h00;
    bus.flag_we    = 1'b0;
    bus.flag_wdata = 4'b0000;
  endtask

  task automatic alu_op(input logic [3:0] mode, input logic [3:0] fl, input logic [7:0] out,
                        input logic wb, input logic [7:0] addr);
    bus.alu_e     = 1'b1;
    bus.mode      = mode;
    bus.alu_flags = fl;
    bus.alu_out   = out;
    bus.wb_en     = wb;
    bus.dst_addr  = addr;
  endtask

  initial begin
    logic [15:0] pushed [$];
    logic [15:0] e;
    idle();
    bus.dmem_ack = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    #6 rst_n = 1'b1;

    // 1: ADD capture, one write pulse acked the following cycle
    alu_op(4'b0000, 4'b0100, 8'h00, 1'b1, 8'h10);
    cycle();
    chk("t1_cflags", 16'(bus.cflags), 16'h0004);
    idle();
    cycle();
    chk("t1_we", 16'(bus.dmem_we), 16'h0001);
    chk("t1_addr_di", {bus.dmem_addr, bus.dmem_di}, 16'h1000);
    bus.dmem_ack = 1'b1;
    cycle();
    bus.dmem_ack = 1'b0;
    chk("t1_we_drop", 16'(bus.dmem_we), 16'h0000);
    chk("t1_writes", 16'(obs_q.size()), 16'd1);

    // 2: logic op keeps C, arithmetic op replaces it
    alu_op(4'b0100, 4'b1000, 8'h00, 1'b0, 8'h00);
    cycle();
    chk("t2_xor", 16'(bus.cflags), 16'h000C);
    alu_op(4'b0001, 4'b0010, 8'h00, 1'b0, 8'h00);
    cycle();
    chk("t2_sub", 16'(bus.cflags), 16'h0002);

    // 3: overflow of the 2-entry buffer with memory stalled
    obs_q.delete();
    alu_op(4'b0000, 4'b0000, 8'hA1, 1'b1, 8'h20);
    cycle();
    alu_op(4'b0000, 4'b0000, 8'hA2, 1'b1, 8'h21);
    cycle();
    chk("t3_stall", 16'(bus.stall), 16'h0001);
    alu_op(4'b0000, 4'b0000, 8'hA3, 1'b1, 8'h22);
    cycle();
    chk("t3_ovf", 16'(bus.ovf_err), 16'h0001);
    idle();
    cycle();
    bus.dmem_ack = 1'b1;
    repeat (4) cycle();
    bus.dmem_ack = 1'b0;
    chk("t3_writes", 16'(obs_q.size()), 16'd2);
    if (obs_q.size() == 2) begin
      chk("t3_first", obs_q[0], 16'h20A1);
      chk("t3_second", obs_q[1], 16'h21A2);
    end

    // 4: direct load beats the ALU update, data still enqueued
    obs_q.delete();
    alu_op(4'b0000, 4'b0000, 8'h55, 1'b1, 8'h30);
    bus.flag_we    = 1'b1;
    bus.flag_wdata = 4'b1111;
    cycle();
    idle();
    chk("t4_cflags", 16'(bus.cflags), 16'h000F);
    chk("t4_busy", 16'(bus.busy), 16'h0001);
    cycle();
    bus.dmem_ack = 1'b1;
    cycle();
    bus.dmem_ack = 1'b0;
    chk("t4_write", obs_q.size() == 1 ? obs_q[0] : 16'hFFFF, 16'h3055);

    // 5: async reset while a write is outstanding
    alu_op(4'b0000, 4'b0000, 8'h77, 1'b1, 8'h40);
    cycle();
    idle();
    cycle();
    chk("t5_we_before", 16'(bus.dmem_we), 16'h0001);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_we", 16'(bus.dmem_we), 16'h0000);
    chk("t5_cflags", 16'(bus.cflags), 16'h0000);
    chk("t5_busy", 16'(bus.busy), 16'h0000);
    check_all();
    #2 rst_n = 1'b1;
    obs_q.delete();
    bus.dmem_ack = 1'b1;
    repeat (4) cycle();
    chk("t5_no_write", 16'(obs_q.size()), 16'd0);

    // 6: streaming with ack tied high; control unit honours stall
    obs_q.delete();
    for (int i = 0; i < 24; i++) begin
      alu_op(4'($urandom_range(0, 15)), 4'($urandom), 8'($urandom), 1'b1, 8'(8'h60 + i));
      bus.wb_en = (m_q.size() < DEPTH);
      if (bus.wb_en) pushed.push_back({bus.dst_addr, bus.alu_out});
      cycle();
      if (i >= 2) chk("t6_stall", 16'(bus.stall), 16'h0000);
    end
    idle();
    repeat (4) cycle();
    chk("t6_count", 16'(obs_q.size()), 16'(pushed.size()));
    for (int i = 0; i < pushed.size() && i < obs_q.size(); i++) begin
      e = pushed[i];
      chk("t6_order", obs_q[i], e);
    end

    // Random traffic against the reference
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus.alu_e      = 1'($urandom_range(0, 1));
      bus.mode       = 4'($urandom_range(0, 15));
      bus.alu_flags  = 4'($urandom);
      bus.alu_out    = 8'($urandom);
      bus.wb_en      = ($urandom_range(0, 3) != 0);
      bus.dst_addr   = 8'($urandom);
      bus.flag_we    = ($urandom_range(0, 9) == 0);
      bus.flag_wdata = 4'($urandom);
      bus.dmem_ack   = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
